// File: rtl/caravel_clock_gen_mc.sv
// Multi-channel clock/reset generator: per-channel pll_clk dividers with glitch-free
// switchover to a synchronised ext_clk, and staged synchronous-deassert channel resets.
//
// state     | meaning
// S_PLL     | clk_out driven by the dividers
// S_P_DRAIN | each channel finishes its high phase, then freezes low
// S_X_WAIT  | all outputs low, waiting for ext_s low
// S_EXT     | clk_out follows ext_s
// S_P_START | one low cycle; counters preset to the low phase, pending divisors applied
module caravel_clock_gen_mc #(
  parameter int NCH         = 2,
  parameter int DIV_W       = 4,
  parameter int RST_STAGES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 pll_clk,
  input  logic                 resetb,
  input  logic                 ext_clk,
  input  logic                 ext_clk_sel,
  input  logic [NCH*DIV_W-1:0] div_n,
  input  logic [NCH-1:0]       div_load,
  input  logic                 ext_reset,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       resetb_sync,
  output logic                 src_ext,
  output logic                 switching
);

  localparam int CW = $clog2(RST_STAGES + 1);

  typedef enum logic [2:0] {S_PLL, S_P_DRAIN, S_X_WAIT, S_EXT, S_P_START} state_t;

  state_t                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      ext_sq, sel_sq, rst_sq;
  logic                        ext_s, sel_s, rst_s;
  logic [NCH-1:0][DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
  logic [NCH-1:0][DIV_W-1:0]   neff_w, start_div_w;
  logic [NCH-1:0]              pend_v_q, pend_v_d, frz_q, frz_d;
  logic [NCH-1:0]              clk_out_q, clk_out_d, prev_q, rise_w, high_w, wrap_w;
  logic [NCH-1:0][CW-1:0]      rcnt_q, rcnt_d;
  logic [NCH-1:0]              rsync_q, rsync_d;

  function automatic logic [DIV_W-1:0] eff(input logic [DIV_W-1:0] n);
    return (n < DIV_W'(2)) ? DIV_W'(2) : n;
  endfunction

  assign ext_s = ext_sq[SYNC_STAGES-1];
  assign sel_s = sel_sq[SYNC_STAGES-1];
  assign rst_s = rst_sq[SYNC_STAGES-1];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign neff_w[g]      = eff(div_q[g]);
    assign high_w[g]      = cnt_q[g] < (neff_w[g] >> 1);
    assign wrap_w[g]      = cnt_q[g] == neff_w[g] - DIV_W'(1);
    assign start_div_w[g] = pend_v_q[g] ? pend_q[g] : div_q[g];
  end

  assign rise_w = clk_out_q & ~prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    frz_d     = '0;
    clk_out_d = '0;
    case (state_q)
      S_PLL:     if (sel_s) state_d = S_P_DRAIN;
      S_P_DRAIN: if (&frz_q) state_d = S_X_WAIT;
      S_X_WAIT:  if (!ext_s) state_d = S_EXT;
      S_EXT:     if (!sel_s && !ext_s) state_d = S_P_START;
      S_P_START: state_d = S_PLL;
      default:   state_d = S_EXT;
    endcase
    for (int i = 0; i < NCH; i++) begin
      case (state_q)
        S_PLL, S_P_DRAIN: begin
          if (state_q == S_P_DRAIN) frz_d[i] = frz_q[i] | ~high_w[i];
          if (!frz_d[i]) begin
            clk_out_d[i] = high_w[i];
            // New divisor only takes effect at a period boundary.
            if (wrap_w[i]) begin
              cnt_d[i] = '0;
              if (pend_v_q[i]) begin
                div_d[i]    = pend_q[i];
                pend_v_d[i] = 1'b0;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
          end
        end
        S_EXT: clk_out_d[i] = ext_s;
        S_P_START: begin
          div_d[i]    = start_div_w[i];
          pend_v_d[i] = 1'b0;
          cnt_d[i]    = eff(start_div_w[i]) >> 1;
        end
        default: ;
      endcase
      if (div_load[i]) begin
        pend_d[i]   = div_n[i*DIV_W +: DIV_W];
        pend_v_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rcnt_d  = rcnt_q;
    rsync_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rst_s) begin
        rcnt_d[i] = '0;
      end else begin
        if (rise_w[i] && rcnt_q[i] != CW'(RST_STAGES)) rcnt_d[i] = rcnt_q[i] + CW'(1);
        rsync_d[i] = rcnt_d[i] == CW'(RST_STAGES);
      end
    end
  end

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_EXT;
      ext_sq    <= '0;
      sel_sq    <= '1;
      rst_sq    <= '0;
      cnt_q     <= '0;
      div_q     <= {NCH{DIV_W'(2)}};
      pend_q    <= '0;
      pend_v_q  <= '0;
      frz_q     <= '0;
      clk_out_q <= '0;
      prev_q    <= '0;
      rcnt_q    <= '0;
      rsync_q   <= '0;
    end else begin
      state_q   <= state_d;
      ext_sq    <= {ext_sq[SYNC_STAGES-2:0], ext_clk};
      sel_sq    <= {sel_sq[SYNC_STAGES-2:0], ext_clk_sel};
      rst_sq    <= {rst_sq[SYNC_STAGES-2:0], ext_reset};
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      frz_q     <= frz_d;
      clk_out_q <= clk_out_d;
      prev_q    <= clk_out_q;
      rcnt_q    <= rcnt_d;
      rsync_q   <= rsync_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign resetb_sync = rsync_q;
  assign src_ext     = state_q == S_EXT;
  assign switching   = (state_q == S_P_DRAIN) || (state_q == S_X_WAIT) || (state_q == S_P_START);

endmodule

// File: tb/tb_caravel_clock_gen_mc.sv
// Directed bench for caravel_clock_gen_mc: ext tracking, switchover, divisor
// reprogramming, soft reset and async reset during drain.
module tb_caravel_clock_gen_mc;

  logic       pll_clk = 1'b0;
  logic       resetb = 1'b0;
  logic       ext_clk = 1'b0;
  logic       ext_clk_sel = 1'b1;
  logic [7:0] div_n = '0;
  logic [1:0] div_load = '0;
  logic       ext_reset = 1'b0;
  logic [1:0] clk_out, resetb_sync;
  logic       src_ext, switching;

  int n_tests = 0;
  int n_fail = 0;

  logic ext_run = 1'b0;
  int   ext_ph = 0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  caravel_clock_gen_mc dut (
    .pll_clk(pll_clk), .resetb(resetb), .ext_clk(ext_clk), .ext_clk_sel(ext_clk_sel),
    .div_n(div_n), .div_load(div_load), .ext_reset(ext_reset),
    .clk_out(clk_out), .resetb_sync(resetb_sync), .src_ext(src_ext), .switching(switching)
  );

  always #5 pll_clk = ~pll_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pll cycle; ext_clk runs at pll/8 and h3 holds the value clk_out should show now.
  task automatic step();
    @(posedge pll_clk);
    #1;
    h3 = h2;
    h2 = h1;
    h1 = ext_clk;
    if (ext_run) begin
      ext_ph++;
      if (ext_ph == 4) begin
        ext_ph = 0;
        ext_clk = ~ext_clk;
      end
    end
  endtask

  task automatic load(input int ch, input logic [3:0] n);
    div_n[ch*4 +: 4] = n;
    div_load[ch] = 1'b1;
    step();
    div_load = '0;
  endtask

  task automatic wait_rise(input int ch, output logic found);
    logic prev;
    found = 1'b0;
    prev = clk_out[ch];
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (clk_out[ch] && !prev) found = 1'b1;
      prev = clk_out[ch];
    end
  endtask

  initial begin
    logic found;
    logic ph3;
    int rises;
    logic [11:0] pat6to2;

    // Reset values
    repeat (3) step();
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_resetb_sync", 32'(resetb_sync), 32'h0);
    chk("rst_src_ext", 32'(src_ext), 32'h1);
    chk("rst_switching", 32'(switching), 32'h0);

    // 1: external source, clk_out = ext_clk delayed 3 cycles; staged reset after 3rd rise
    resetb = 1'b1;
    ext_run = 1'b1;
    rises = 0;
    ph3 = 1'b0;
    for (int n = 0; n < 48; n++) begin
      step();
      chk("t1_clk0", 32'(clk_out[0]), 32'(h3));
      chk("t1_clk1", 32'(clk_out[1]), 32'(h3));
      chk("t1_rsync", 32'(resetb_sync), (rises >= 3) ? 32'h3 : 32'h0);
      if (h3 && !ph3) rises++;
      ph3 = h3;
    end
    chk("t1_src_ext", 32'(src_ext), 32'h1);

    // 2: switch to PLL with ch0 N=4, ch1 N=3
    ext_clk_sel = 1'b0;
    div_n = {4'd3, 4'd4};
    div_load = 2'b11;
    step();
    div_load = '0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (!src_ext && !switching) found = 1'b1;
      else if (switching) chk("t2_glitch", 32'(clk_out), 32'h0);
    end
    chk("t2_switch_done", 32'(found), 32'h1);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      chk("t2_ch0", 32'(clk_out[0]), (k > 0 && ((k - 1) % 4) >= 2) ? 32'h1 : 32'h0);
      chk("t2_ch1", 32'(clk_out[1]), (k > 0 && ((k - 1) % 3) == 2) ? 32'h1 : 32'h0);
      chk("t2_src_ext", 32'(src_ext), 32'h0);
    end

    // 3: ch0 N=6, then load N=2 one cycle into a high phase
    load(0, 4'd6);
    repeat (20) step();
    wait_rise(0, found);
    chk("t3_sync", 32'(found), 32'h1);
    pat6to2 = 12'b010101000111;
    for (int k = 1; k < 12; k++) begin
      step();
      chk("t3_ch0", 32'(clk_out[0]), 32'(pat6to2[k]));
      if (k == 1) begin
        div_n[3:0] = 4'd2;
        div_load = 2'b01;
      end else begin
        div_load = '0;
      end
    end

    // 4: N=0 and N=1 both divide by 2
    for (int v = 0; v < 2; v++) begin
      load(0, 4'(v));
      repeat (10) step();
      wait_rise(0, found);
      chk("t4_sync", 32'(found), 32'h1);
      for (int k = 1; k < 9; k++) begin
        step();
        chk(v == 0 ? "t4_n0" : "t4_n1", 32'(clk_out[0]), (k % 2 == 0) ? 32'h1 : 32'h0);
      end
    end

    // 5: one-cycle ext_reset pulse
    chk("t5_pre", 32'(resetb_sync), 32'h3);
    ext_reset = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      ext_reset = 1'b0;
      if (s == 3) chk("t5_low_s3", 32'(resetb_sync), 32'h0);
      if (s == 7) chk("t5_low_s7", 32'(resetb_sync), 32'h0);
      if (s == 9) chk("t5_ch0_up", 32'(resetb_sync), 32'h1);
      if (s == 12) chk("t5_both_up", 32'(resetb_sync), 32'h3);
    end

    // 6: async reset during P_DRAIN
    ext_clk_sel = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (switching) found = 1'b1;
    end
    chk("t6_drain_seen", 32'(found), 32'h1);
    #2;
    resetb = 1'b0;
    #2;
    chk("t6_clk_out", 32'(clk_out), 32'h0);
    chk("t6_resetb_sync", 32'(resetb_sync), 32'h0);
    chk("t6_src_ext", 32'(src_ext), 32'h1);
    chk("t6_switching", 32'(switching), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
